// File: rtl/salamander_pkg.sv
// Shared types and widths for the fetch stage and the downstream decoder.
package salamander_pkg;

  localparam int unsigned INSTR_W    = 6;
  localparam int unsigned EXEC_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DECODE = 2'd2,
    EXEC   = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_pc.sv
// Program counter register: synchronous reset to RESET_PC, load has priority over increment.
module pc_counter #(
  parameter int unsigned PC_W     = 5,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= PC_W'(RESET_PC);
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch/sequencing stage: owns PC and IR, fetches over req/ack, strobes the decoder,
// then holds for a (stallable) execute phase before the next fetch.
module instr_fetch
  import salamander_pkg::*;
#(
  parameter int unsigned PC_W        = 5,
  parameter int unsigned RESET_PC    = 0,
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RUN,
  input  logic               HALT,
  input  logic               STALL,
  input  logic               JMP_EN,
  input  logic [PC_W-1:0]    JMP_ADDR,
  output logic               MEM_REQ,
  output logic [PC_W-1:0]    MEM_ADDR,
  input  logic [INSTR_W-1:0] MEM_RDATA,
  input  logic               MEM_ACK,
  output logic [INSTR_W-1:0] INSTR,
  output logic               ID_CE,
  output logic [PC_W-1:0]    PC,
  output logic               BUSY
);

  fetch_state_t          state;
  fetch_state_t          state_next;
  logic [EXEC_CNT_W-1:0] cnt;
  logic [EXEC_CNT_W-1:0] cnt_next;
  logic                  ir_load;
  logic                  pc_inc;
  logic                  pc_load;

  pc_counter #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (CLK),
    .rst      (RST),
    .inc      (pc_inc),
    .load     (pc_load),
    .load_val (JMP_ADDR),
    .pc       (PC)
  );

  assign MEM_ADDR = PC;

  // State, IR and exec counter; strobes are registered from the next state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      INSTR   <= '0;
      MEM_REQ <= 1'b0;
      ID_CE   <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      if (ir_load) begin
        INSTR <= MEM_RDATA;
      end
      MEM_REQ <= (state_next == FETCH);
      ID_CE   <= (state_next == DECODE);
      BUSY    <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    case (state)
      IDLE: begin
        if (RUN && !HALT) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (MEM_ACK) begin
          ir_load    = 1'b1;
          pc_inc     = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        cnt_next   = EXEC_CNT_W'(EXEC_CYCLES - 1);
        state_next = EXEC;
      end
      EXEC: begin
        // Jump and run/halt are only honoured on the final, unstalled exec cycle.
        if (cnt != '0) begin
          cnt_next = cnt - EXEC_CNT_W'(1);
        end else if (!STALL) begin
          pc_load    = JMP_EN;
          state_next = (HALT || !RUN) ? IDLE : FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: two instances (default params, and RESET_PC=31/EXEC_CYCLES=3)
// driven by shared directed and random stimulus, checked against a transaction-level model.
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       rst, run, halt, stall, jmp_en, mem_ack;
  logic [4:0] jmp_addr;
  logic [5:0] mem_rdata;

  logic       a_mem_req, a_id_ce, a_busy, b_mem_req, b_id_ce, b_busy;
  logic [4:0] a_mem_addr, a_pc, b_mem_addr, b_pc;
  logic [5:0] a_instr, b_instr;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: phase 0=idle 1=fetching 2=decode strobe 3=executing; left = exec cycles still owed.
  int m_phase [2];
  int m_pc    [2];
  int m_ir    [2];
  int m_left  [2];
  int p_rst_pc[2] = '{0, 31};
  int p_exec  [2] = '{1, 3};

  always #5 clk = ~clk;

  instr_fetch #(.PC_W(5), .RESET_PC(0), .EXEC_CYCLES(1)) dut_a (
    .CLK(clk), .RST(rst), .RUN(run), .HALT(halt), .STALL(stall),
    .JMP_EN(jmp_en), .JMP_ADDR(jmp_addr), .MEM_REQ(a_mem_req), .MEM_ADDR(a_mem_addr),
    .MEM_RDATA(mem_rdata), .MEM_ACK(mem_ack), .INSTR(a_instr), .ID_CE(a_id_ce),
    .PC(a_pc), .BUSY(a_busy)
  );

  instr_fetch #(.PC_W(5), .RESET_PC(31), .EXEC_CYCLES(3)) dut_b (
    .CLK(clk), .RST(rst), .RUN(run), .HALT(halt), .STALL(stall),
    .JMP_EN(jmp_en), .JMP_ADDR(jmp_addr), .MEM_REQ(b_mem_req), .MEM_ADDR(b_mem_addr),
    .MEM_RDATA(mem_rdata), .MEM_ACK(mem_ack), .INSTR(b_instr), .ID_CE(b_id_ce),
    .PC(b_pc), .BUSY(b_busy)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_clock(input int k);
    if (rst) begin
      m_phase[k] = 0; m_pc[k] = p_rst_pc[k]; m_ir[k] = 0; m_left[k] = 0;
    end else begin
      case (m_phase[k])
        0: if (run && !halt) m_phase[k] = 1;
        1: if (mem_ack) begin
             m_ir[k] = int'(mem_rdata);
             m_pc[k] = (m_pc[k] + 1) % 32;
             m_phase[k] = 2;
           end
        2: begin m_left[k] = p_exec[k]; m_phase[k] = 3; end
        default: begin
          if (m_left[k] > 1) m_left[k] = m_left[k] - 1;
          else if (!stall) begin
            if (jmp_en) m_pc[k] = int'(jmp_addr);
            m_phase[k] = (halt || !run) ? 0 : 1;
          end
        end
      endcase
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare all outputs.
  task automatic step();
    @(posedge clk);
    model_clock(0);
    model_clock(1);
    #1;
    check("a_req",  32'(a_mem_req),  int'(m_phase[0] == 1));
    check("a_ce",   32'(a_id_ce),    int'(m_phase[0] == 2));
    check("a_busy", 32'(a_busy),     int'(m_phase[0] != 0));
    check("a_addr", 32'(a_mem_addr), m_pc[0]);
    check("a_pc",   32'(a_pc),       m_pc[0]);
    check("a_ir",   32'(a_instr),    m_ir[0]);
    check("b_req",  32'(b_mem_req),  int'(m_phase[1] == 1));
    check("b_ce",   32'(b_id_ce),    int'(m_phase[1] == 2));
    check("b_busy", 32'(b_busy),     int'(m_phase[1] != 0));
    check("b_addr", 32'(b_mem_addr), m_pc[1]);
    check("b_pc",   32'(b_pc),       m_pc[1]);
    check("b_ir",   32'(b_instr),    m_ir[1]);
  endtask

  task automatic do_reset();
    rst = 1'b1; step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; halt = 1'b0; stall = 1'b0; jmp_en = 1'b0;
    jmp_addr = '0; mem_ack = 1'b0; mem_rdata = '0;
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 0; m_pc[k] = 0; m_ir[k] = 0; m_left[k] = 0;
    end
    step(); step();
    check("rst_a_pc", 32'(a_pc), 0);
    check("rst_b_pc", 32'(b_pc), 31);
    check("rst_a_req", 32'(a_mem_req), 0);

    // Immediate ack, one instruction per three cycles
    rst = 1'b0; run = 1'b1; mem_ack = 1'b1; mem_rdata = 6'b101101;
    step();
    check("t1_req", 32'(a_mem_req), 1);
    check("t1_addr", 32'(a_mem_addr), 0);
    step();
    check("t1_ce", 32'(a_id_ce), 1);
    check("t1_ir", 32'(a_instr), 45);
    check("t1_pc", 32'(a_pc), 1);
    check("t4_wrap", 32'(b_pc), 0);
    step(); step();
    check("t1_req2", 32'(a_mem_req), 1);
    check("t1_addr2", 32'(a_mem_addr), 1);

    // Delayed ack: request held four cycles with a stable address
    do_reset();
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t2_req", 32'(a_mem_req), 1);
      check("t2_addr", 32'(a_mem_addr), 0);
    end
    mem_ack = 1'b1; mem_rdata = 6'h13;
    step();
    check("t2_ce", 32'(a_id_ce), 1);
    check("t2_pc", 32'(a_pc), 1);
    mem_ack = 1'b0;
    step();
    check("t2_ce_once", 32'(a_id_ce), 0);

    // Jump: ignored during decode, taken in the last exec cycle
    do_reset();
    mem_ack = 1'b1;
    step(); step();
    jmp_en = 1'b1; jmp_addr = 5'd12;
    step();
    jmp_en = 1'b0;
    step();
    check("t3_nojmp", 32'(a_mem_addr), 1);
    step(); step();
    jmp_en = 1'b1; jmp_addr = 5'd12;
    step();
    jmp_en = 1'b0;
    check("t3_jmp", 32'(a_mem_addr), 12);

    // Exec of three cycles stretched by two stall cycles
    do_reset();
    mem_ack = 1'b1;
    step(); step();
    check("t4_pc", 32'(b_pc), 0);
    for (int i = 0; i < 5; i++) begin
      stall = (i >= 2);
      step();
      check("t4_exec_req", 32'(b_mem_req), 0);
      check("t4_exec_busy", 32'(b_busy), 1);
    end
    stall = 1'b0;
    step();
    check("t4_refetch", 32'(b_mem_req), 1);

    // Halt while waiting for ack completes the instruction then idles
    do_reset();
    mem_ack = 1'b0;
    step();
    halt = 1'b1;
    step(); step();
    mem_ack = 1'b1;
    step();
    check("t5_ce", 32'(a_id_ce), 1);
    mem_ack = 1'b0;
    step(); step();
    check("t5_idle", 32'(a_busy), 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t5_noreq", 32'(a_mem_req), 0);
    end
    halt = 1'b0;
    step(); step();
    check("t5_resume", 32'(a_mem_req), 1);

    // Reset mid-handshake
    do_reset();
    mem_ack = 1'b0; run = 1'b1;
    step(); step();
    rst = 1'b1;
    step();
    check("t6_req", 32'(a_mem_req), 0);
    check("t6_ce", 32'(a_id_ce), 0);
    check("t6_pc", 32'(a_pc), 0);
    check("t6_ir", 32'(a_instr), 0);
    check("t6_busy", 32'(a_busy), 0);
    rst = 1'b0;

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 59) == 0);
      run       = ($urandom_range(0, 7) != 0);
      halt      = ($urandom_range(0, 7) == 0);
      stall     = ($urandom_range(0, 3) == 0);
      jmp_en    = ($urandom_range(0, 3) == 0);
      jmp_addr  = 5'($urandom);
      mem_ack   = ($urandom_range(0, 1) == 0);
      mem_rdata = 6'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
